// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the data memory controller.
//   dmc_state_t : controller FSM states
//   mem_width_t : RISC-V load/store func3 width codes
//   BE_WIDTH    : SRAM byte-enable width
//   req_legal() : true when a request may touch the SRAM
package data_mem_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } dmc_state_t;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_t;

  localparam int BE_WIDTH = 4;

  // Unsigned widths exist only for loads; simultaneous read/write is never legal.
  function automatic logic req_legal(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (mem_width_t'(f3))
      MW_B:    ok = 1'b1;
      MW_H:    ok = !a[0];
      MW_W:    ok = (a == 2'b00);
      MW_BU:   ok = rd;
      MW_HU:   ok = rd && !a[0];
      default: ok = 1'b0;
    endcase
    return ok && !(rd && wr);
  endfunction

endpackage

// File: rtl/data_mem_controller_if.sv
// Mem-stage request bus plus SRAM port of the data memory controller.
//   master : processor/SRAM side (drives requests and sramRData)
//   slave  : controller side
interface data_mem_controller_if
  import data_mem_controller_pkg::*;
#(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32
);
  localparam int AW = $clog2(DM_MEM_DEPTH);

  logic                  memRead;
  logic                  memWrite;
  logic [2:0]            func3;
  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wData;
  logic [DATA_WIDTH-1:0] dMOut;
  logic                  dMReady;
  logic                  misalignErr;
  logic [AW-1:0]         sramAddr;
  logic [31:0]           sramWData;
  logic [BE_WIDTH-1:0]   sramBe;
  logic                  sramWen;
  logic                  sramRen;
  logic [31:0]           sramRData;

  modport master (
    output memRead, memWrite, func3, addr, wData, sramRData,
    input  dMOut, dMReady, misalignErr, sramAddr, sramWData, sramBe, sramWen, sramRen
  );

  modport slave (
    input  memRead, memWrite, func3, addr, wData, sramRData,
    output dMOut, dMReady, misalignErr, sramAddr, sramWData, sramBe, sramWen, sramRen
  );
endinterface

// File: rtl/data_mem_controller_align.sv
// load_store_align: combinational lane steering for the data memory controller.
//   func3_i   : load/store width code
//   addr_lo_i : byte offset within the word
//   wdata_i   : store data        -> wdata_o : lane-replicated store data
//   rdata_i   : SRAM read word    -> ldata_o : extracted, extended load data
//   be_o      : byte enables for the access width/offset
module load_store_align
  import data_mem_controller_pkg::*;
(
  input  logic [2:0]          func3_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [31:0]         wdata_i,
  input  logic [31:0]         rdata_i,
  output logic [BE_WIDTH-1:0] be_o,
  output logic [31:0]         wdata_o,
  output logic [31:0]         ldata_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    ldata_o  = '0;

    // Narrow stores replicate the datum so whichever lane is enabled sees it.
    case (func3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: be_o = 4'b1111;
    endcase

    case (mem_width_t'(func3_i))
      MW_B:    ldata_o = {{24{byte_sel[7]}}, byte_sel};
      MW_H:    ldata_o = {{16{half_sel[15]}}, half_sel};
      MW_W:    ldata_o = rdata_i;
      MW_BU:   ldata_o = {24'h0, byte_sel};
      MW_HU:   ldata_o = {16'h0, half_sel};
      default: ldata_o = '0;
    endcase
  end
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: Mem-stage load/store sequencer for a single-port SRAM.
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : slave view of data_mem_controller_if (requests, load result,
//          ready, sticky error, SRAM address/data/enables/strobes)
//
// state     | meaning
// ST_IDLE   | waiting; ready when no request, captures request on the edge
// ST_ACCESS | one cycle, SRAM strobe high (legal requests only)
// ST_WAIT   | WAIT_CYCLES cycles of SRAM wait states (down-counter)
// ST_DONE   | one cycle, ready high, load data presented
module data_mem_controller
  import data_mem_controller_pkg::*;
#(
  parameter int DM_MEM_DEPTH = 4096,
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_CYCLES  = 1
)(
  input logic                  clk,
  input logic                  rstN,
  data_mem_controller_if.slave bus
);
  localparam int         AW        = $clog2(DM_MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  dmc_state_t            state_q;
  logic [3:0]            cnt_q;
  logic [AW+1:0]         addr_q;
  logic [2:0]            func3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_q;
  logic                  ok_q;
  logic                  err_q;
  logic                  wen_q;
  logic                  ren_q;

  logic                  req;
  logic                  ok;
  logic [BE_WIDTH-1:0]   be;
  logic [31:0]           ldata;
  logic                  unused_addr_hi;

  assign req            = bus.memRead | bus.memWrite;
  assign ok             = req_legal(bus.memRead, bus.memWrite, bus.func3, bus.addr[1:0]);
  assign unused_addr_hi = ^bus.addr[31:AW+2];

  load_store_align u_align (
    .func3_i   (func3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (bus.sramRData),
    .be_o      (be),
    .wdata_o   (bus.sramWData),
    .ldata_o   (ldata)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      func3_q <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= bus.addr[AW+1:0];
            func3_q <= bus.func3;
            wdata_q <= bus.wData;
            rd_q    <= bus.memRead;
            ok_q    <= ok;
            wen_q   <= bus.memWrite & ok;
            ren_q   <= bus.memRead & ok;
            if (!ok) err_q <= 1'b1;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          wen_q <= 1'b0;
          ren_q <= 1'b0;
          if (WAIT_CYCLES > 0) begin
            cnt_q   <= WAIT_LOAD;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) state_q <= ST_DONE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.sramWen     = wen_q;
  assign bus.sramRen     = ren_q;
  assign bus.sramAddr    = addr_q[AW+1:2];
  assign bus.sramBe      = (wen_q | ren_q) ? be : '0;
  assign bus.misalignErr = err_q;
  assign bus.dMReady     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign bus.dMOut       = (state_q == ST_DONE && rd_q && ok_q) ? ldata : '0;
endmodule

// File: tb/tb_data_mem_controller.sv
module tb_data_mem_controller;
  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  data_mem_controller_if #(.DM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32)) bus0 ();
  data_mem_controller_if #(.DM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32)) bus1 ();

  data_mem_controller #(.DM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_CYCLES(1))
    dut0 (.clk(clk), .rstN(rstN), .bus(bus0.slave));
  data_mem_controller #(.DM_MEM_DEPTH(DEPTH), .DATA_WIDTH(32), .WAIT_CYCLES(0))
    dut1 (.clk(clk), .rstN(rstN), .bus(bus1.slave));

  // SRAM models with strobe bookkeeping
  logic [31:0] sram0 [DEPTH];
  logic [31:0] sram1 [DEPTH];
  int wen_cnt0 = 0, ren_cnt0 = 0, both0 = 0;
  int wen_cnt1 = 0, ren_cnt1 = 0, both1 = 0;
  logic [7:0]  lw_addr0;
  logic [3:0]  lw_be0;
  logic [31:0] lw_data0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int w = 0; w < DEPTH; w++) sram0[w] <= 32'h0;
    end else begin
      if (bus0.sramWen) begin
        for (int i = 0; i < 4; i++)
          if (bus0.sramBe[i]) sram0[bus0.sramAddr][8*i +: 8] <= bus0.sramWData[8*i +: 8];
        wen_cnt0 <= wen_cnt0 + 1;
        lw_addr0 <= bus0.sramAddr;
        lw_be0   <= bus0.sramBe;
        lw_data0 <= bus0.sramWData;
      end
      if (bus0.sramRen) begin
        bus0.sramRData <= sram0[bus0.sramAddr];
        ren_cnt0 <= ren_cnt0 + 1;
      end
      if (bus0.sramWen && bus0.sramRen) both0 <= both0 + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int w = 0; w < DEPTH; w++) sram1[w] <= 32'h0;
    end else begin
      if (bus1.sramWen) begin
        for (int i = 0; i < 4; i++)
          if (bus1.sramBe[i]) sram1[bus1.sramAddr][8*i +: 8] <= bus1.sramWData[8*i +: 8];
        wen_cnt1 <= wen_cnt1 + 1;
      end
      if (bus1.sramRen) begin
        bus1.sramRData <= sram1[bus1.sramAddr];
        ren_cnt1 <= ren_cnt1 + 1;
      end
      if (bus1.sramWen && bus1.sramRen) both1 <= both1 + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte-addressed memory image and sticky error per instance
  logic [7:0] refm [2][BYTES];
  logic       err_exp [2];

  function automatic logic req_rejected(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [31:0] a);
    logic bad;
    bad = (rd && wr) || (wr && f3 > 3'd2) || (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
    if (f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [2:0] f3, input logic [31:0] a);
    int n, base;
    logic [31:0] v;
    n = 1 << f3[1:0];
    base = int'(a % 32'(BYTES));
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(refm[s][base+k]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input int s, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n, base;
    n = 1 << f3[1:0];
    base = int'(a % 32'(BYTES));
    for (int k = 0; k < n; k++) refm[s][base+k] = 8'(d >> (8*k));
  endtask

  function automatic logic        get_rdy(input int s);  return s == 0 ? bus0.dMReady : bus1.dMReady; endfunction
  function automatic logic [31:0] get_dout(input int s); return s == 0 ? bus0.dMOut : bus1.dMOut; endfunction
  function automatic logic        get_err(input int s);  return s == 0 ? bus0.misalignErr : bus1.misalignErr; endfunction
  function automatic int          get_wen(input int s);  return s == 0 ? wen_cnt0 : wen_cnt1; endfunction
  function automatic int          get_ren(input int s);  return s == 0 ? ren_cnt0 : ren_cnt1; endfunction

  task automatic drive(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus0.memRead = rd; bus0.memWrite = wr; bus0.func3 = f3; bus0.addr = a; bus0.wData = d;
    end else begin
      bus1.memRead = rd; bus1.memWrite = wr; bus1.func3 = f3; bus1.addr = a; bus1.wData = d;
    end
  endtask

  // One request held until dMReady; lat counts cycles from the request cycle.
  task automatic access(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] dout, output int nw, output int nr,
                        output logic rdy0);
    int w0, r0;
    @(negedge clk);
    w0 = get_wen(s);
    r0 = get_ren(s);
    drive(s, rd, wr, f3, a, d);
    #1 rdy0 = get_rdy(s);
    lat = 99;
    dout = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      #1;
      if (get_rdy(s)) begin
        lat = c;
        dout = get_dout(s);
        break;
      end
    end
    drive(s, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    nw = get_wen(s) - w0;
    nr = get_ren(s) - r0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (bus0.dMReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready0: got %b expected 1", bus0.dMReady); end
    n_checks++; if (bus1.dMReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready1: got %b expected 1", bus1.dMReady); end
    n_checks++; if (bus0.dMOut !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h expected 0", bus0.dMOut); end
    n_checks++; if (bus0.misalignErr !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", bus0.misalignErr); end
    n_checks++; if ({bus0.sramWen, bus0.sramRen} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b expected 00", {bus0.sramWen, bus0.sramRen}); end
    n_checks++; if (bus0.sramBe !== 4'h0) begin n_fail++; $display("FAIL rst_be: got %b expected 0000", bus0.sramBe); end
    @(negedge clk);
    rstN = 1'b1;
    mem_clear = 1'b0;
    #1;
    n_checks++; if (bus0.dMReady !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", bus0.dMReady); end
  endtask

  task automatic test_sw;
    int lat, nw, nr; logic [31:0] dout; logic r0;
    access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, dout, nw, nr, r0);
    model_store(0, 3'b010, 32'h10, 32'hDEADBEEF);
    n_checks++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL sw_ready_drop: got %b expected 0", r0); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    n_checks++; if (nw !== 1 || nr !== 0) begin n_fail++; $display("FAIL sw_strobes: got wen=%0d ren=%0d expected 1/0", nw, nr); end
    n_checks++; if (lw_addr0 !== 8'd4) begin n_fail++; $display("FAIL sw_addr: got %0d expected 4", lw_addr0); end
    n_checks++; if (lw_be0 !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b expected 1111", lw_be0); end
    n_checks++; if (lw_data0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", lw_data0); end
  endtask

  task automatic test_byte;
    int lat, nw, nr; logic [31:0] dout; logic r0;
    access(0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5, lat, dout, nw, nr, r0);
    model_store(0, 3'b000, 32'h13, 32'h000000A5);
    n_checks++; if (lw_be0 !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b expected 1000", lw_be0); end
    n_checks++; if (lw_data0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", lw_data0); end
    access(0, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (dout !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_data: got %h expected ffffffa5", dout); end
    access(0, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (dout !== 32'h000000A5) begin n_fail++; $display("FAIL lbu_data: got %h expected 000000a5", dout); end
  endtask

  task automatic test_half;
    int lat, nw, nr; logic [31:0] dout; logic r0;
    access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h80017FFF, lat, dout, nw, nr, r0);
    model_store(0, 3'b010, 32'h10, 32'h80017FFF);
    access(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (dout !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h expected ffff8001", dout); end
    access(0, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (dout !== 32'h00007FFF) begin n_fail++; $display("FAIL lhu_data: got %h expected 00007fff", dout); end
  endtask

  task automatic test_misalign;
    int lat, nw, nr; logic [31:0] dout; logic r0;
    access(0, 1'b1, 1'b0, 3'b010, 32'h2, 32'h0, lat, dout, nw, nr, r0);
    err_exp[0] = 1'b1;
    n_checks++; if (bus0.misalignErr !== 1'b1) begin n_fail++; $display("FAIL mis_err: got %b expected 1", bus0.misalignErr); end
    n_checks++; if (nr !== 0 || nw !== 0) begin n_fail++; $display("FAIL mis_strobes: got ren=%0d wen=%0d expected 0/0", nr, nw); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL mis_latency: got %0d expected 3", lat); end
    n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL mis_dout: got %h expected 0", dout); end
  endtask

  task automatic test_back_to_back;
    int lat, nw, nr; logic [31:0] dout, val; logic r0;
    val = $urandom;
    access(1, 1'b0, 1'b1, 3'b010, 32'h40, val, lat, dout, nw, nr, r0);
    model_store(1, 3'b010, 32'h40, val);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_sw_latency: got %0d expected 2", lat); end
    access(1, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_lw_latency: got %0d expected 2", lat); end
    n_checks++; if (dout !== val) begin n_fail++; $display("FAIL b2b_lw_data: got %h expected %h", dout, val); end
  endtask

  task automatic test_reset_mid_access;
    int lat, nw, nr, w0; logic [31:0] dout; logic r0;
    access(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, lat, dout, nw, nr, r0);
    model_store(0, 3'b010, 32'h20, 32'h11111111);
    // Reset lands while the write strobe is up, before the SRAM samples it.
    @(negedge clk);
    w0 = wen_cnt0;
    drive(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h22222222);
    @(negedge clk);
    #1;
    n_checks++; if (bus0.sramWen !== 1'b1) begin n_fail++; $display("FAIL mid_wen_pending: got %b expected 1", bus0.sramWen); end
    rstN = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    #1;
    n_checks++; if (bus0.sramWen !== 1'b0 || bus0.sramBe !== 4'h0) begin n_fail++; $display("FAIL mid_rst_strobe: got wen=%b be=%b expected 0/0000", bus0.sramWen, bus0.sramBe); end
    n_checks++; if (bus0.dMReady !== 1'b1 || bus0.misalignErr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got ready=%b err=%b expected 1/0", bus0.dMReady, bus0.misalignErr); end
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    #1;
    n_checks++; if (wen_cnt0 !== w0) begin n_fail++; $display("FAIL mid_no_write: got %0d writes expected 0", wen_cnt0 - w0); end
    access(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (dout !== 32'h11111111) begin n_fail++; $display("FAIL mid_old_word: got %h expected 11111111", dout); end
  endtask

  task automatic test_reset_in_wait;
    int lat, nw, nr; logic [31:0] dout, exp_d; logic r0;
    access(0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h0, lat, dout, nw, nr, r0);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 3'b000, 32'h25, 32'h0000005C);
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (bus0.dMReady !== 1'b0) begin n_fail++; $display("FAIL wait_busy: got %b expected 0", bus0.dMReady); end
    rstN = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    #1;
    n_checks++; if (bus0.dMReady !== 1'b1 || bus0.misalignErr !== 1'b0 || bus0.dMOut !== 32'h0) begin n_fail++; $display("FAIL wait_rst: got ready=%b err=%b dout=%h expected 1/0/0", bus0.dMReady, bus0.misalignErr, bus0.dMOut); end
    // The byte strobe had already been issued in ACCESS, so the store stands.
    model_store(0, 3'b000, 32'h25, 32'h0000005C);
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    exp_d = model_load(0, 3'b100, 32'h25);
    access(0, 1'b1, 1'b0, 3'b100, 32'h25, 32'h0, lat, dout, nw, nr, r0);
    n_checks++; if (lat !== 3 || dout !== exp_d) begin n_fail++; $display("FAIL wait_after: got lat=%0d dout=%h expected 3/%h", lat, dout, exp_d); end
  endtask

  task automatic test_random(input int s, input int w);
    int lat, nw, nr, r; logic [31:0] dout, a, d, exp_d; logic rd, wr, bad, r0; logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 15);
      rd = (r < 8);
      wr = (r == 0) || (r >= 8);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom << 10) | 32'($urandom_range(0, 63));
      d  = $urandom;
      bad = req_rejected(rd, wr, f3, a);
      exp_d = (rd && !bad) ? model_load(s, f3, a) : 32'h0;
      if (wr && !bad) model_store(s, f3, a, d);
      if (bad) err_exp[s] = 1'b1;
      access(s, rd, wr, f3, a, d, lat, dout, nw, nr, r0);
      n_checks++; if (lat !== 2 + w) begin n_fail++; $display("FAIL rnd%0d_%0d latency: got %0d expected %0d", s, i, lat, 2 + w); end
      n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL rnd%0d_%0d dout: rd=%b wr=%b f3=%0d a=%h got %h expected %h", s, i, rd, wr, f3, a, dout, exp_d); end
      n_checks++; if (nw !== int'(wr && !bad) || nr !== int'(rd && !bad)) begin n_fail++; $display("FAIL rnd%0d_%0d strobes: got wen=%0d ren=%0d expected %0d/%0d", s, i, nw, nr, int'(wr && !bad), int'(rd && !bad)); end
      n_checks++; if (get_err(s) !== err_exp[s]) begin n_fail++; $display("FAIL rnd%0d_%0d err: got %b expected %b", s, i, get_err(s), err_exp[s]); end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      err_exp[s] = 1'b0;
      for (int b = 0; b < BYTES; b++) refm[s][b] = 8'h0;
    end
    drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    test_reset;
    test_sw;
    test_byte;
    test_half;
    test_misalign;
    test_back_to_back;
    test_reset_mid_access;
    test_reset_in_wait;
    test_random(0, 1);
    test_random(1, 0);
    n_checks++; if (both0 + both1 !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both0 + both1); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
